// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for a 5-stage MIPS pipe: EX operand mux selects plus IF/ID/EX stall/flush.
// Latency: outputs are combinational from the shadow stages and ID inputs; the shadow stages advance one per clock.
// Backpressure: mem_ready=0 freezes every shadow stage and the counter, and holds IF/ID through stall_f/stall_d.
// Optional HAZ_BRANCH_FWD_EN: ID-stage branch operand forwarding (forward_ad/bd) and branch stalls.
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              flush_d,
  input  logic              mem_ready,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  lu_stall_cnt
`ifdef HAZ_BRANCH_FWD_EN
  ,
  input  logic              id_branch,
  output logic              forward_ad,
  output logic              forward_bd
`endif
);

  // Register-field shadow of one pipeline stage; all-zero is a bubble.
  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memtoreg;
  } stage_t;

  stage_t ex_q, mem_q, wb_q;
  stage_t id_s;

  logic freeze;
  logic ex_load;
  logic lwstall;
  logic branchstall;
  logic hazstall;

  // Source-operand select: the youngest producer (MEM) beats the older one (WB); $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_AW-1:0] src,
                                         input stage_t m, input stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && m.regwrite && (m.dst != '0) && (m.dst == src)) begin
      sel = 2'b10;
    end else if (uses && w.regwrite && (w.dst != '0) && (w.dst == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Pack the ID-stage fields into the shadow-stage layout.
  always_comb begin
    id_s          = '0;
    id_s.rs       = id_rs;
    id_s.rt       = id_rt;
    id_s.uses_rs  = id_uses_rs;
    id_s.uses_rt  = id_uses_rt;
    id_s.dst      = id_dst;
    id_s.regwrite = id_regwrite;
    id_s.memtoreg = id_memtoreg;
  end

  assign freeze  = ~mem_ready;
  assign ex_load = ex_q.memtoreg & ex_q.regwrite & (ex_q.dst != '0);
  assign lwstall = id_valid & ex_load &
                   ((id_uses_rs & (id_rs == ex_q.dst)) | (id_uses_rt & (id_rt == ex_q.dst)));

`ifdef HAZ_BRANCH_FWD_EN
  // Early branch compare in ID: forward MEM ALU results, stall on anything not yet available.
  always_comb begin
    forward_ad  = (id_rs != '0) & mem_q.regwrite & (mem_q.dst == id_rs);
    forward_bd  = (id_rt != '0) & mem_q.regwrite & (mem_q.dst == id_rt);
    branchstall = id_branch &
                  ((ex_q.regwrite & (ex_q.dst != '0) &
                    ((ex_q.dst == id_rs) | (ex_q.dst == id_rt))) |
                   (mem_q.memtoreg & (mem_q.dst != '0) &
                    ((mem_q.dst == id_rs) | (mem_q.dst == id_rt))));
  end
`else
  assign branchstall = 1'b0;
`endif

  assign hazstall = lwstall | branchstall;

  // Operand selects follow the held state, so they stay valid through a freeze.
  assign forward_ae = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
  assign forward_be = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);

  // Pipeline control, priority freeze > flush_d > hazard stall; quiet while reset is asserted.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_e = 1'b0;
    if (reset_n) begin
      if (freeze) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
      end else if (flush_d) begin
        flush_e = 1'b1;
      end else if (hazstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Advance the shadow stages and count load-use stall cycles (saturating).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      lu_stall_cnt <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush_d || hazstall || !id_valid) begin
        ex_q <= '0;
      end else begin
        ex_q <= id_s;
      end
      if (!flush_d && lwstall && (lu_stall_cnt != {CNT_W{1'b1}})) begin
        lu_stall_cnt <= lu_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomised bench for hazard_forward_unit with a scoreboard against an instruction-level pipeline model.
// The driver pushes the expected outputs each cycle; a separate monitor pops and compares mid-cycle.
// A narrow counter (CNT_W=3) lets the bench reach saturation.
module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 3;
  localparam int NCYC = 1500;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          id_uses_rs, id_uses_rt, id_regwrite, id_memtoreg;
  logic          flush_d, mem_ready;
  logic [1:0]    forward_ae, forward_be;
  logic          stall_f, stall_d, flush_e;
  logic [CW-1:0] lu_stall_cnt;
`ifdef HAZ_BRANCH_FWD_EN
  logic          id_branch = 1'b0;
  logic          forward_ad, forward_bd;
`endif

  hazard_forward_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .flush_d(flush_d), .mem_ready(mem_ready),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .lu_stall_cnt(lu_stall_cnt)
`ifdef HAZ_BRANCH_FWD_EN
    , .id_branch(id_branch), .forward_ad(forward_ad), .forward_bd(forward_bd)
`endif
  );

  always #5 clk = ~clk;

  // One instruction as seen by the hazard rules; a bubble neither reads nor writes.
  typedef struct {
    int rs, rt, dst;
    bit urs, urt, rw, ld;
  } ins_t;

  typedef struct {
    logic [1:0]    fa, fb;
    logic          sf, sd, fe;
    logic [CW-1:0] cnt;
  } exp_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_cnt;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   driver_done = 1'b0;

  function automatic ins_t bubble();
    ins_t b;
    b.rs = 0; b.rt = 0; b.dst = 0;
    b.urs = 0; b.urt = 0; b.rw = 0; b.ld = 0;
    return b;
  endfunction

  // Where does the EX consumer get register r from: nearest older writer, $0 always from the file.
  function automatic logic [1:0] src_of(bit uses, int r);
    if (!uses || r == 0) return 2'b00;
    if (m_mem.rw && m_mem.dst == r) return 2'b10;
    if (m_wb.rw && m_wb.dst == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    bit reads;
    reads = (id_uses_rs && int'(id_rs) == m_ex.dst) || (id_uses_rt && int'(id_rt) == m_ex.dst);
    return id_valid && m_ex.ld && m_ex.rw && m_ex.dst != 0 && reads;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.fa = 2'b00; e.fb = 2'b00; e.sf = 1'b0; e.sd = 1'b0; e.fe = 1'b0; e.cnt = '0;
    if (reset_n) begin
      e.fa  = src_of(m_ex.urs, m_ex.rs);
      e.fb  = src_of(m_ex.urt, m_ex.rt);
      e.cnt = CW'(m_cnt);
      if (!mem_ready) begin
        e.sf = 1'b1; e.sd = 1'b1;
      end else if (flush_d) begin
        e.fe = 1'b1;
      end else if (load_use()) begin
        e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    m_ex = bubble(); m_mem = bubble(); m_wb = bubble(); m_cnt = 0;
  endtask

  task automatic step_model();
    bit   lw;
    ins_t nxt;
    if (!reset_n || !mem_ready) return;
    lw = load_use();
    if (flush_d || lw || !id_valid) begin
      nxt = bubble();
    end else begin
      nxt.rs = int'(id_rs); nxt.rt = int'(id_rt); nxt.dst = int'(id_dst);
      nxt.urs = id_uses_rs; nxt.urt = id_uses_rt; nxt.rw = id_regwrite; nxt.ld = id_memtoreg;
    end
    if (lw && !flush_d && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = nxt;
  endtask

  task automatic chk(string name, int act, int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a settled output set mid-cycle; compare it with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("forward_ae", int'(forward_ae), int'(e.fa));
        chk("forward_be", int'(forward_be), int'(e.fb));
        chk("stall_f", int'(stall_f), int'(e.sf));
        chk("stall_d", int'(stall_d), int'(e.sd));
        chk("flush_e", int'(flush_e), int'(e.fe));
        chk("lu_stall_cnt", int'(lu_stall_cnt), int'(e.cnt));
      end
    end
  end

  // Driver: random instructions over a few registers so that hazards are frequent.
  initial begin
    reset_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0; id_memtoreg = 1'b0;
    flush_d = 1'b0; mem_ready = 1'b1;
    clear_model();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c < 3 || (c >= 400 && c < 403) || (c >= 900 && c < 902)) begin
        reset_n = 1'b0;
        clear_model();
      end else begin
        reset_n = 1'b1;
      end
      id_valid    = ($urandom_range(0, 99) < 85);
      id_rs       = AW'($urandom_range(0, 3));
      id_rt       = AW'($urandom_range(0, 3));
      id_dst      = AW'($urandom_range(0, 3));
      id_uses_rs  = ($urandom_range(0, 99) < 70);
      id_uses_rt  = ($urandom_range(0, 99) < 70);
      id_regwrite = ($urandom_range(0, 99) < 70);
      id_memtoreg = ($urandom_range(0, 99) < 40);
      flush_d     = ($urandom_range(0, 99) < 10);
      mem_ready   = ($urandom_range(0, 99) < 85);
      sb.push_back(predict());
      @(posedge clk);
      step_model();
    end
    driver_done = 1'b1;
  end

  // End of run: bounded drain of the scoreboard, then the summary.
  initial begin
    wait (driver_done);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #3;
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #((NCYC + 100) * 10 * 2);
    failures = failures + 1;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
